// File: rtl/flash_mem_arbiter_if.sv
// Bus bundle for flash_mem_arbiter: two word-read requesters (A, B),
// the downstream flash read port, the config-write strobe and status outputs.
// The arbiter connects through the slave modport. Master is the driving side
// (requesters plus flash model).
interface flash_mem_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_addr;
  logic [31:0] a_rdata;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_addr;
  logic [31:0] b_rdata;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        cfg_we;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  a_valid, a_addr, b_valid, b_addr, mem_ready, mem_rdata, cfg_we,
    output a_ready, a_rdata, b_ready, b_rdata, mem_valid, mem_addr, busy, timeout_err
  );

  modport master (
    output a_valid, a_addr, b_valid, b_addr, mem_ready, mem_rdata, cfg_we,
    input  a_ready, a_rdata, b_ready, b_rdata, mem_valid, mem_addr, busy, timeout_err
  );
endinterface

// File: rtl/flash_mem_arbiter.sv
// flash_mem_arbiter: round-robin arbiter that lets two word-read requesters
// share one flash read port. Each transaction runs IDLE -> ACCESS -> RESP.
// The downstream wait is bounded by TIMEOUT_CYCLES. On expiry the requester
// gets 0xFFFFFFFF and a timeout_err pulse.
// Optional feature: define FLASH_ARB_RBUF_EN to add a one-word read buffer.
// A lookup that hits the buffer skips the flash access. The buffer is
// invalidated by cfg_we.
module flash_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  flash_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q;
  logic               gnt_b_q;     // requester owning the current transaction (1 = B)
  logic               pref_b_q;    // round-robin pointer: prefer B on a tie
  logic               mem_valid_q;
  logic [23:0]        mem_addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_ready_q;
  logic               b_ready_q;
  logic [31:0]        a_rdata_q;
  logic [31:0]        b_rdata_q;
  logic               busy_q;
  logic               terr_q;

  logic               gnt_any_d;
  logic               gnt_b_d;
  logic [21:0]        waddr_d;
  logic               hit_d;
  logic [31:0]        hit_data;

  // Arbitration decision for the IDLE cycle: a lone request wins. On a tie the pointer decides.
  always_comb begin
    gnt_any_d = bus.a_valid | bus.b_valid;
    gnt_b_d   = bus.b_valid & (~bus.a_valid | pref_b_q);
    waddr_d   = gnt_b_d ? bus.b_addr[23:2] : bus.a_addr[23:2];
  end

`ifdef FLASH_ARB_RBUF_EN
  logic        rbuf_vld_q;
  logic [21:0] rbuf_tag_q;
  logic [31:0] rbuf_data_q;

  // A cfg_we in the lookup cycle forces a miss, so stale data is never returned.
  assign hit_d    = rbuf_vld_q & (rbuf_tag_q == waddr_d) & ~bus.cfg_we;
  assign hit_data = rbuf_data_q;

  // Read buffer: filled by successful flash reads only and invalidated by config writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_vld_q <= 1'b0;
    end else if (bus.cfg_we) begin
      rbuf_vld_q <= 1'b0;
    end else if (state_q == ACCESS && bus.mem_ready) begin
      rbuf_vld_q <= 1'b1;
    end
    if (state_q == ACCESS && bus.mem_ready) begin
      rbuf_tag_q  <= mem_addr_q[23:2];
      rbuf_data_q <= bus.mem_rdata;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.a_addr[31:24], bus.a_addr[1:0], bus.b_addr[31:24], bus.b_addr[1:0]};
`else
  assign hit_d    = 1'b0;
  assign hit_data = 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.a_addr[31:24], bus.a_addr[1:0], bus.b_addr[31:24],
                         bus.b_addr[1:0], bus.cfg_we};
`endif

  // Transaction FSM. Every output is a register and is updated on the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_b_q     <= 1'b0;
      pref_b_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 24'h0;
      cnt_q       <= '0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      a_rdata_q   <= 32'h0;
      b_rdata_q   <= 32'h0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      terr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_any_d) begin
            gnt_b_q    <= gnt_b_d;
            pref_b_q   <= ~gnt_b_d;
            mem_addr_q <= {waddr_d, 2'b00};
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (hit_d) begin
              state_q   <= RESP;
              a_ready_q <= ~gnt_b_d;
              b_ready_q <= gnt_b_d;
              if (gnt_b_d) b_rdata_q <= hit_data;
              else         a_rdata_q <= hit_data;
            end else begin
              state_q     <= ACCESS;
              mem_valid_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // A mem_ready in the final counted cycle still counts as success.
          if (bus.mem_ready) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
            a_ready_q   <= ~gnt_b_q;
            b_ready_q   <= gnt_b_q;
            if (gnt_b_q) b_rdata_q <= bus.mem_rdata;
            else         a_rdata_q <= bus.mem_rdata;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
            a_ready_q   <= ~gnt_b_q;
            b_ready_q   <= gnt_b_q;
            terr_q      <= 1'b1;
            if (gnt_b_q) b_rdata_q <= 32'hFFFF_FFFF;
            else         a_rdata_q <= 32'hFFFF_FFFF;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.a_ready     = a_ready_q;
  assign bus.b_ready     = b_ready_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_flash_mem_arbiter.sv
// Testbench for flash_mem_arbiter.
// Instance dut uses the default timeout. Instance dut_to uses TIMEOUT_CYCLES=15.
// Building with FLASH_ARB_RBUF_EN also exercises the read buffer.
module tb_flash_mem_arbiter;
  logic clk = 1'b0;
  logic rst1;
  logic rst2;
  int   total = 0;
  int   bad   = 0;

  flash_mem_arbiter_if bus1();
  flash_mem_arbiter_if bus2();

  flash_mem_arbiter #(.TIMEOUT_CYCLES(1023)) dut    (.clk(clk), .reset(rst1), .bus(bus1));
  flash_mem_arbiter #(.TIMEOUT_CYCLES(15))   dut_to (.clk(clk), .reset(rst2), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.a_valid = 0; bus1.a_addr = 0; bus1.b_valid = 0; bus1.b_addr = 0;
    bus1.mem_ready = 0; bus1.mem_rdata = 0; bus1.cfg_we = 0;
    bus2.a_valid = 0; bus2.a_addr = 0; bus2.b_valid = 0; bus2.b_addr = 0;
    bus2.mem_ready = 0; bus2.mem_rdata = 0; bus2.cfg_we = 0;
  endtask

  task automatic test_reset();
    rst1 = 1; rst2 = 1;
    step(2);
    total++; if (bus1.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b want=0", bus1.mem_valid); end
    total++; if (bus1.mem_addr !== 24'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", bus1.mem_addr); end
    total++; if (bus1.a_ready !== 1'b0 || bus1.b_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b%b want=00", bus1.a_ready, bus1.b_ready); end
    total++; if (bus1.a_rdata !== 32'h0 || bus1.b_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", bus1.a_rdata, bus1.b_rdata); end
    total++; if (bus1.busy !== 1'b0 || bus1.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_status got=%b%b want=00", bus1.busy, bus1.timeout_err); end
    total++; if (bus2.mem_valid !== 1'b0 || bus2.busy !== 1'b0) begin bad++; $display("FAIL rst_dut_to got=%b%b want=00", bus2.mem_valid, bus2.busy); end
    rst1 = 0; rst2 = 0;
    step(1);
  endtask

  task automatic test_single_read();
    int errs = 0;
    bus1.a_addr = 32'h0010_0004; bus1.a_valid = 1;
    for (int c = 1; c <= 21; c++) begin
      step(1);
      if (bus1.mem_valid !== 1'b1 || bus1.mem_addr !== 24'h100004 || bus1.a_ready !== 1'b0 ||
          bus1.b_ready !== 1'b0 || bus1.busy !== 1'b1) errs++;
      if (c == 21) begin bus1.mem_ready = 1; bus1.mem_rdata = 32'hDEAD_BEEF; end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL single_access_hold got=%0d bad cycles want=0", errs); end
    step(1);
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_resp got=%b/%h want=1/deadbeef", bus1.a_ready, bus1.a_rdata); end
    total++; if (bus1.b_ready !== 1'b0 || bus1.mem_valid !== 1'b0) begin bad++; $display("FAIL single_other got=%b%b want=00", bus1.b_ready, bus1.mem_valid); end
    bus1.a_valid = 0; bus1.mem_ready = 0;
    step(1);
    total++; if (bus1.a_ready !== 1'b0 || bus1.busy !== 1'b0) begin bad++; $display("FAIL single_done got=%b%b want=00", bus1.a_ready, bus1.busy); end
  endtask

  task automatic test_ready_ignored();
    int errs = 0;
    bus1.mem_ready = 1; bus1.mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (bus1.a_ready !== 1'b0 || bus1.b_ready !== 1'b0 || bus1.busy !== 1'b0 || bus1.mem_valid !== 1'b0) errs++;
    end
    bus1.mem_ready = 0;
    total++; if (errs != 0) begin bad++; $display("FAIL ready_ignored got=%0d bad cycles want=0", errs); end
  endtask

  task automatic test_round_robin();
    logic [23:0] exp_addr [3];
    logic        exp_b    [3];
    logic [31:0] dat      [3];
    int n;
    exp_addr[0] = 24'hABCDE8; exp_b[0] = 0; dat[0] = 32'h1111_1111;
    exp_addr[1] = 24'h123454; exp_b[1] = 1; dat[1] = 32'h2222_2222;
    exp_addr[2] = 24'hABCDE8; exp_b[2] = 0; dat[2] = 32'h3333_3333;
    rst1 = 1; step(1); rst1 = 0;
    bus1.a_addr = 32'h00AB_CDEB; bus1.b_addr = 32'hFF12_3457;
    bus1.a_valid = 1; bus1.b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin step(1); n++; end while (bus1.mem_valid !== 1'b1 && n < 10);
      total++; if (bus1.mem_valid !== 1'b1) begin bad++; $display("FAIL rr_wait[%0d] got=%b want=1", i, bus1.mem_valid); end
      total++; if (bus1.mem_addr !== exp_addr[i]) begin bad++; $display("FAIL rr_addr[%0d] got=%h want=%h", i, bus1.mem_addr, exp_addr[i]); end
      bus1.mem_ready = 1; bus1.mem_rdata = dat[i];
      step(1);
      bus1.mem_ready = 0;
      total++; if (bus1.a_ready !== ~exp_b[i] || bus1.b_ready !== exp_b[i]) begin bad++; $display("FAIL rr_ready[%0d] got=a%b b%b want=a%b b%b", i, bus1.a_ready, bus1.b_ready, ~exp_b[i], exp_b[i]); end
      total++; if ((exp_b[i] ? bus1.b_rdata : bus1.a_rdata) !== dat[i]) begin bad++; $display("FAIL rr_rdata[%0d] got=%h want=%h", i, exp_b[i] ? bus1.b_rdata : bus1.a_rdata, dat[i]); end
      if (exp_b[i]) bus1.b_valid = 0;
    end
    bus1.a_valid = 0;
    step(2);
  endtask

  task automatic test_reset_mid_access();
    int n;
    bus1.a_addr = 32'h0000_1230; bus1.a_valid = 1;
    step(3);
    total++; if (bus1.mem_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b want=1", bus1.mem_valid); end
    rst1 = 1;
    step(1);
    total++; if (bus1.mem_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.a_ready !== 1'b0) begin bad++; $display("FAIL rmid_abort got=mv%b busy%b rdy%b want=000", bus1.mem_valid, bus1.busy, bus1.a_ready); end
    rst1 = 0;
    n = 0;
    do begin step(1); n++; end while (bus1.mem_valid !== 1'b1 && n < 10);
    total++; if (bus1.mem_valid !== 1'b1 || bus1.mem_addr !== 24'h001230) begin bad++; $display("FAIL rmid_retry got=%b/%h want=1/001230", bus1.mem_valid, bus1.mem_addr); end
    bus1.mem_ready = 1; bus1.mem_rdata = 32'h0BAD_F00D;
    step(1);
    bus1.mem_ready = 0;
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL rmid_resp got=%b/%h want=1/0badf00d", bus1.a_ready, bus1.a_rdata); end
    bus1.a_valid = 0;
    step(2);
  endtask

  task automatic test_timeout();
    int errs = 0;
    bus2.a_addr = 32'h0000_0040; bus2.a_valid = 1;
    for (int c = 1; c <= 15; c++) begin
      step(1);
      if (bus2.mem_valid !== 1'b1 || bus2.timeout_err !== 1'b0 || bus2.a_ready !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL tmo_hold got=%0d bad cycles want=0", errs); end
    step(1);
    total++; if (bus2.mem_valid !== 1'b0) begin bad++; $display("FAIL tmo_drop got=%b want=0", bus2.mem_valid); end
    total++; if (bus2.a_ready !== 1'b1 || bus2.a_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmo_resp got=%b/%h want=1/ffffffff", bus2.a_ready, bus2.a_rdata); end
    total++; if (bus2.timeout_err !== 1'b1 || bus2.b_ready !== 1'b0) begin bad++; $display("FAIL tmo_err got=%b b%b want=1 b0", bus2.timeout_err, bus2.b_ready); end
    bus2.a_valid = 0;
    step(1);
    total++; if (bus2.timeout_err !== 1'b0 || bus2.a_ready !== 1'b0 || bus2.busy !== 1'b0) begin bad++; $display("FAIL tmo_after got=%b%b%b want=000", bus2.timeout_err, bus2.a_ready, bus2.busy); end
  endtask

  task automatic test_timeout_edge();
    bus2.a_addr = 32'h0000_0080; bus2.a_valid = 1;
    for (int c = 1; c <= 15; c++) begin
      step(1);
      if (c == 15) begin bus2.mem_ready = 1; bus2.mem_rdata = 32'h1234_5678; end
    end
    step(1);
    bus2.mem_ready = 0;
    total++; if (bus2.a_ready !== 1'b1 || bus2.a_rdata !== 32'h1234_5678) begin bad++; $display("FAIL tmo_edge_resp got=%b/%h want=1/12345678", bus2.a_ready, bus2.a_rdata); end
    total++; if (bus2.timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_edge_err got=%b want=0", bus2.timeout_err); end
    bus2.a_valid = 0;
    step(2);
  endtask

  task automatic test_read_buffer();
    // read 1: always a flash access
    bus1.a_addr = 32'h0000_0200; bus1.a_valid = 1;
    step(1);
    total++; if (bus1.mem_valid !== 1'b1 || bus1.mem_addr !== 24'h000200) begin bad++; $display("FAIL rb_first got=%b/%h want=1/000200", bus1.mem_valid, bus1.mem_addr); end
    bus1.mem_ready = 1; bus1.mem_rdata = 32'hCAFE_0200;
    step(1);
    bus1.mem_ready = 0; bus1.a_valid = 0;
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'hCAFE_0200) begin bad++; $display("FAIL rb_first_resp got=%b/%h want=1/cafe0200", bus1.a_ready, bus1.a_rdata); end
    step(1);
    // read 2: same word
    bus1.a_valid = 1;
    step(1);
`ifdef FLASH_ARB_RBUF_EN
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'hCAFE_0200 || bus1.mem_valid !== 1'b0) begin bad++; $display("FAIL rb_hit got=rdy%b %h mv%b want=rdy1 cafe0200 mv0", bus1.a_ready, bus1.a_rdata, bus1.mem_valid); end
    bus1.a_valid = 0;
    step(1);
`else
    total++; if (bus1.mem_valid !== 1'b1 || bus1.a_ready !== 1'b0) begin bad++; $display("FAIL rb_nobuf got=mv%b rdy%b want=mv1 rdy0", bus1.mem_valid, bus1.a_ready); end
    bus1.mem_ready = 1; bus1.mem_rdata = 32'hCAFE_0201;
    step(1);
    bus1.mem_ready = 0; bus1.a_valid = 0;
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'hCAFE_0201) begin bad++; $display("FAIL rb_nobuf_resp got=%b/%h want=1/cafe0201", bus1.a_ready, bus1.a_rdata); end
    step(1);
`endif
    // config write invalidates, read 3 must go downstream
    bus1.cfg_we = 1;
    step(1);
    bus1.cfg_we = 0;
    bus1.a_valid = 1;
    step(1);
    total++; if (bus1.mem_valid !== 1'b1 || bus1.a_ready !== 1'b0) begin bad++; $display("FAIL rb_after_cfg got=mv%b rdy%b want=mv1 rdy0", bus1.mem_valid, bus1.a_ready); end
    bus1.mem_ready = 1; bus1.mem_rdata = 32'h5555_AAAA;
    step(1);
    bus1.mem_ready = 0; bus1.a_valid = 0;
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL rb_after_cfg_resp got=%b/%h want=1/5555aaaa", bus1.a_ready, bus1.a_rdata); end
    step(1);
    // read 4: cfg_we coincident with lookup forces a miss
    bus1.a_valid = 1; bus1.cfg_we = 1;
    step(1);
    bus1.cfg_we = 0;
    total++; if (bus1.mem_valid !== 1'b1 || bus1.a_ready !== 1'b0) begin bad++; $display("FAIL rb_cfg_same got=mv%b rdy%b want=mv1 rdy0", bus1.mem_valid, bus1.a_ready); end
    bus1.mem_ready = 1; bus1.mem_rdata = 32'h7777_0000;
    step(1);
    bus1.mem_ready = 0; bus1.a_valid = 0;
    total++; if (bus1.a_ready !== 1'b1 || bus1.a_rdata !== 32'h7777_0000) begin bad++; $display("FAIL rb_cfg_same_resp got=%b/%h want=1/77770000", bus1.a_ready, bus1.a_rdata); end
    step(2);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_ready_ignored();
    test_round_robin();
    test_reset_mid_access();
    test_timeout();
    test_timeout_edge();
    test_read_buffer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
